// File: rtl/rr_mux41_arbiter_pkg.sv
// Shared constants, state encoding and round-robin search helper for the
// 4-requester mux arbiter.
package rr_mux41_arbiter_pkg;

   localparam int unsigned NREQ  = 4;
   localparam int unsigned IDX_W = 2;

   typedef enum logic {
      IDLE = 1'b0,
      OWN  = 1'b1
   } state_e;

   typedef struct packed {
      logic             found;
      logic [IDX_W-1:0] idx;
   } pick_t;

   // First set bit of req, searching from last+1 and wrapping back to last.
   function automatic pick_t next_rr(input logic [NREQ-1:0]  req,
                                     input logic [IDX_W-1:0] last);
      pick_t            p;
      logic [IDX_W-1:0] cand;
      p = '0;
      for (int unsigned k = 1; k <= NREQ; k++) begin
         cand = last + IDX_W'(k);
         if (!p.found && req[cand]) begin
            p.found = 1'b1;
            p.idx   = cand;
         end
      end
      return p;
   endfunction

endpackage

// File: rtl/mux41_sel.sv
// Combinational single-bit 4:1 mux; din[{s1,s0}] drives y_o.
module mux41_sel (
   input  logic [3:0] din_i,
   input  logic       s1_i,
   input  logic       s0_i,
   output logic       y_o
);

   always_comb begin
      y_o = 1'b0;
      case ({s1_i, s0_i})
         2'b00:   y_o = din_i[0];
         2'b01:   y_o = din_i[1];
         2'b10:   y_o = din_i[2];
         default: y_o = din_i[3];
      endcase
   end

endmodule

// File: rtl/rr_mux41_arbiter.sv
// Round-robin arbiter owning a shared 4:1 single-bit mux; an owner keeps the
// mux for at most MAX_HOLD consecutive cycles while anyone else is waiting.
module rr_mux41_arbiter
   import rr_mux41_arbiter_pkg::*;
#(
   parameter int unsigned MAX_HOLD = 4,
   parameter int unsigned CW       = 3
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [NREQ-1:0] req_i,
   input  logic [NREQ-1:0] din_i,
   output logic [NREQ-1:0] gnt_o,
   output logic            s1_o,
   output logic            s0_o,
   output logic            busy_o,
   output logic            out_o
);

   state_e           state_q, state_d;
   logic [NREQ-1:0]  gnt_q, gnt_d;
   logic [IDX_W-1:0] sel_q, sel_d;
   logic             busy_q, busy_d;
   logic [CW-1:0]    hold_q, hold_d;
   logic [IDX_W-1:0] last_q, last_d;

   logic [NREQ-1:0]  own_mask;
   logic             own_req;
   logic             hold_full;
   pick_t            pick_idle;
   pick_t            pick_rot;
   logic             grant_en;
   logic [IDX_W-1:0] grant_idx;
   logic             mux_y;

   assign own_mask  = NREQ'(1) << sel_q;
   assign own_req   = req_i[sel_q];
   assign hold_full = (hold_q == CW'(MAX_HOLD));
   assign pick_idle = next_rr(req_i, last_q);
   // Owner is masked so a forced rotation can never re-pick the current owner.
   assign pick_rot  = next_rr(req_i & ~own_mask, sel_q);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         gnt_q   <= '0;
         sel_q   <= '0;
         busy_q  <= 1'b0;
         hold_q  <= '0;
         last_q  <= IDX_W'(NREQ - 1);
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         sel_q   <= sel_d;
         busy_q  <= busy_d;
         hold_q  <= hold_d;
         last_q  <= last_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      gnt_d     = gnt_q;
      sel_d     = sel_q;
      busy_d    = busy_q;
      hold_d    = hold_q;
      last_d    = last_q;
      grant_en  = 1'b0;
      grant_idx = '0;

      case (state_q)
         IDLE: begin
            if (pick_idle.found) begin
               grant_en  = 1'b1;
               grant_idx = pick_idle.idx;
            end
         end
         OWN: begin
            // A drop coinciding with hold expiry falls into the same branch.
            if (!own_req || hold_full) begin
               if (pick_rot.found) begin
                  grant_en  = 1'b1;
                  grant_idx = pick_rot.idx;
               end else if (!own_req) begin
                  state_d = IDLE;
                  gnt_d   = '0;
                  busy_d  = 1'b0;
                  hold_d  = '0;
               end
            end else begin
               hold_d = hold_q + CW'(1);
            end
         end
         default: begin
            state_d = IDLE;
            gnt_d   = '0;
            busy_d  = 1'b0;
         end
      endcase

      if (grant_en) begin
         state_d = OWN;
         gnt_d   = NREQ'(1) << grant_idx;
         sel_d   = grant_idx;
         busy_d  = 1'b1;
         hold_d  = CW'(1);
         last_d  = grant_idx;
      end
   end

   mux41_sel u_mux (
      .din_i (din_i),
      .s1_i  (sel_q[1]),
      .s0_i  (sel_q[0]),
      .y_o   (mux_y)
   );

   assign gnt_o  = gnt_q;
   assign s1_o   = sel_q[1];
   assign s0_o   = sel_q[0];
   assign busy_o = busy_q;
   assign out_o  = busy_q & mux_y;

endmodule

// File: doc/rr_mux41_arbiter.md
Name: rr_mux41_arbiter

Overview:
- Round-robin arbiter that shares one 4:1 single-bit mux among four requesters.
- Owns the mux select lines s1/s0 and the mux output path, and issues a one-hot grant.
- Each owner holds the mux for up to MAX_HOLD cycles when others are waiting.
- Sits between requesting blocks and the shared 4:1 mux datapath; the mux function is instantiated internally.

Parameters:
- MAX_HOLD, 4, maximum consecutive cycles one owner keeps the mux while another request is pending (legal range 1..(2**CW)-1).
- CW, 3, width of the hold counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- req  input  4  request per requester; bit i = requester i.
- din  input  4  data bit per requester; din[i] is mux input i (i=0..3 maps to a,b,c,d).
- gnt  output 4  registered one-hot grant; all zero when idle.
- s1   output 1  registered mux select MSB.
- s0   output 1  registered mux select LSB.
- busy output 1  registered; 1 while any grant is active.
- out  output 1  din[{s1,s0}] when busy, else 0; combinational from registered state.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high, sampled on the rising edge.
- Reset values: gnt=0000, s1=0, s0=0, busy=0, out=0, hold_cnt=0, last=3, so requester 0 has top priority after reset.
- Reset mid-operation: an active grant is dropped at the next edge; no release handshake.
- States:
  - IDLE: busy=0, gnt=0.
  - OWN: busy=1, gnt one-hot, {s1,s0} = binary index of the owner.
- Priority order: search starts at last+1 mod 4 and wraps (e.g. last=1 gives order 2,3,0,1). last is updated to the new owner index on every new grant.
- IDLE to OWN: on an edge with req!=0, pick the first requester in priority order. gnt, s1/s0 and busy take effect at that edge, so latency from req seen to gnt is 1 cycle. hold_cnt=1.
- OWN, owner's req sampled 0:
  - Other requests present: hand off at the same edge to the next requester in priority order after the owner. No idle bubble; hold_cnt=1.
  - No other requests: go to IDLE; gnt=0, busy=0, s1/s0 keep their last value.
- OWN, owner's req=1 and hold_cnt==MAX_HOLD:
  - Any other req: forced rotation to the next requester after the owner; hold_cnt=1.
  - No other req: keep the grant; hold_cnt saturates at MAX_HOLD.
- OWN, owner's req=1 and hold_cnt<MAX_HOLD: keep the grant; hold_cnt+1.
- Invariants:
  - gnt is always zero or one-hot.
  - gnt[i]=1 implies {s1,s0}==i.
  - A requester with req held high is granted within 3*MAX_HOLD+3 cycles (starvation bound).
- Simultaneous events: owner drop and hold expiry in the same cycle are treated as a drop. A requester newly raising req in the same cycle as a handoff is eligible in that same arbitration.
- out path: out = busy ? din[{s1,s0}] : 0. No register on din, so a din change is visible on out in the same cycle.

Decomposition:
- Shared package / header:
  - requester count constant NREQ=4;
  - state encodings IDLE=1'b0, OWN=1'b1;
  - a function next_rr(req, last) returning the index and a found flag.
- One natural sub-module, mux41_sel: a combinational 4:1 mux taking din, s1 and s0. The arbiter instantiates it, gating its output with busy.
- Arbitration and hold counter stay in the top module, roughly 150-250 lines of RTL.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, req=0000 -> gnt=0000, s1=0, s0=0, busy=0, out=0; these hold for 5 cycles after rst=0.
- Single requester: req=0100, din=0100 -> next edge gnt=0100, s1=1, s0=0, busy=1, out=1; drop req -> next edge gnt=0000, busy=0, out=0.
- Simultaneous post-reset: req=1111 held, MAX_HOLD=4 -> grants 0001 for 4 cycles, then 0010, 0100, 1000 (4 cycles each), then back to 0001. Edge-to-edge handoff with no idle cycle.
- Early release handoff: owner 0 (req=0011) drops bit0 after 2 cycles -> next edge gnt=0010, s1=0, s0=1, hold_cnt=1; there is no busy=0 cycle.
- Saturation: req=0001 held alone for 10 cycles -> gnt stays 0001 throughout. When req becomes 1001 after hold_cnt has saturated, rotation to 1000 happens at the next edge.
- Reset mid-grant: owner 2 active, assert rst -> next edge gnt=0000, busy=0, s1=0, s0=0. After release with req=0110, grant goes to 0010 (last reset to 3).
